// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register (instruction + next-PC)
// with a valid/ready upstream handshake backed by a one-entry skid buffer,
// synchronous flush, bubble collapse and a programmable hold limit.
//
// Optional feature macro: STALL_CNT_EN (adds the stall_cnt output and its counter).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     upstream payload valid
//   in_ready     stage can accept (registered, equals !skid_valid)
//   in_ins       upstream instruction word
//   in_npc       upstream next-PC
//   hold         downstream stall request
//   flush        synchronous kill of output and skid contents
//   out_valid    output payload valid
//   out_ins      registered instruction word
//   out_npc      registered next-PC
//   hold_forced  high when a hold request is overridden by the hold limit
//   stall_cnt    saturating count of honoured stall cycles (STALL_CNT_EN only)
module pipe_stage_reg #(
  parameter int INS_W       = 32,
  parameter int PC_W        = 32,
  parameter int MAX_HOLD    = 1,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INS_W-1:0]       in_ins,
  input  logic [PC_W-1:0]        in_npc,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [INS_W-1:0]       out_ins,
  output logic [PC_W-1:0]        out_npc,
  output logic                   hold_forced
`ifdef STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  logic             skid_valid;
  logic [INS_W-1:0] skid_ins;
  logic [PC_W-1:0]  skid_npc;
  logic [HC_W-1:0]  hold_cnt;

  logic accept;
  logic limit_hit;
  logic hold_eff;
  logic adv;

  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;

  generate
    if (MAX_HOLD == 0) begin : g_no_limit
      assign limit_hit = 1'b0;
    end else begin : g_limit
      localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);
      assign limit_hit = (hold_cnt == HOLD_LIM);
    end
  endgenerate

  // An empty output register never honours hold, so bubbles collapse.
  assign hold_eff    = hold & out_valid & !limit_hit;
  assign hold_forced = hold & out_valid & limit_hit;
  assign adv         = !hold_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      hold_cnt   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      hold_cnt   <= '0;
    end else if (adv) begin
      hold_cnt <= '0;
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
      end
    end else begin
      hold_cnt <= hold_cnt + HC_W'(1);
      if (accept) skid_valid <= 1'b1;
    end
  end

  // Payload registers are left untouched by flush and by bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_ins  <= '0;
      out_npc  <= '0;
      skid_ins <= '0;
      skid_npc <= '0;
    end else if (!flush) begin
      if (adv) begin
        if (skid_valid) begin
          out_ins <= skid_ins;
          out_npc <= skid_npc;
        end else if (accept) begin
          out_ins <= in_ins;
          out_npc <= in_npc;
        end
      end else if (accept) begin
        skid_ins <= in_ins;
        skid_npc <= in_npc;
      end
    end
  end

`ifdef STALL_CNT_EN
  // Saturating; deliberately not cleared by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (hold_eff && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_ins = '0;
  logic [31:0] in_npc = '0;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        ov[2];
  logic        ir[2];
  logic        hf[2];
  logic [31:0] oi[2];
  logic [31:0] on[2];
`ifdef STALL_CNT_EN
  logic [31:0] sc[2];
`endif

  // u0: unlimited hold, u1: hold limit of one cycle; both see the same stimulus.
  pipe_stage_reg #(.INS_W(32), .PC_W(32), .MAX_HOLD(0), .STALL_CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ins(in_ins), .in_npc(in_npc), .hold(hold), .flush(flush),
    .out_valid(ov[0]), .out_ins(oi[0]), .out_npc(on[0]), .hold_forced(hf[0])
`ifdef STALL_CNT_EN
    , .stall_cnt(sc[0])
`endif
  );

  pipe_stage_reg #(.INS_W(32), .PC_W(32), .MAX_HOLD(1), .STALL_CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ins(in_ins), .in_npc(in_npc), .hold(hold), .flush(flush),
    .out_valid(ov[1]), .out_ins(oi[1]), .out_npc(on[1]), .hold_forced(hf[1])
`ifdef STALL_CNT_EN
    , .stall_cnt(sc[1])
`endif
  );

  // Model: the stage is a FIFO of at most two entries (output + skid);
  // entry 0 is what is shown. disp keeps the last shown payload for bubbles.
  int          mh[2] = '{0, 1};
  int          mn[2];
  int          mhc[2];
  logic [31:0] mqi[2][2];
  logic [31:0] mqn[2][2];
  logic [31:0] di[2];
  logic [31:0] dn[2];
`ifdef STALL_CNT_EN
  logic [31:0] msc[2];
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k]  = 0;
      mhc[k] = 0;
      di[k]  = '0;
      dn[k]  = '0;
`ifdef STALL_CNT_EN
      msc[k] = '0;
`endif
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic acc, lim, stl;
      acc = in_valid && (mn[k] < 2);
      lim = (mh[k] != 0) && (mhc[k] == mh[k]);
      stl = hold && (mn[k] >= 1) && !lim;
      if (flush) begin
        mn[k]  = 0;
        mhc[k] = 0;
      end else if (!stl) begin
        if (mn[k] >= 1) begin
          mqi[k][0] = mqi[k][1];
          mqn[k][0] = mqn[k][1];
          mn[k]--;
        end
        if (acc) begin
          mqi[k][mn[k]] = in_ins;
          mqn[k][mn[k]] = in_npc;
          mn[k]++;
        end
        mhc[k] = 0;
      end else begin
        if (acc) begin
          mqi[k][mn[k]] = in_ins;
          mqn[k][mn[k]] = in_npc;
          mn[k]++;
        end
        mhc[k]++;
`ifdef STALL_CNT_EN
        if (msc[k] != 32'hFFFF_FFFF) msc[k]++;
`endif
      end
      if (mn[k] >= 1) begin
        di[k] = mqi[k][0];
        dn[k] = mqn[k][0];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d out_valid", k), 64'(ov[k]), 64'(mn[k] >= 1));
      chk($sformatf("u%0d in_ready", k), 64'(ir[k]), 64'(mn[k] < 2));
      chk($sformatf("u%0d out_ins", k), 64'(oi[k]), 64'(di[k]));
      chk($sformatf("u%0d out_npc", k), 64'(on[k]), 64'(dn[k]));
      chk($sformatf("u%0d hold_forced", k), 64'(hf[k]),
          64'(hold && (mn[k] >= 1) && (mh[k] != 0) && (mhc[k] == mh[k])));
`ifdef STALL_CNT_EN
      chk($sformatf("u%0d stall_cnt", k), 64'(sc[k]), 64'(msc[k]));
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic h, input logic f);
    in_valid = v;
    in_ins   = ins;
    in_npc   = ins + 32'h1000;
    hold     = h;
    flush    = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    #1;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst out_valid", 64'(ov[0]), 64'd0);
    chk("rst in_ready", 64'(ir[0]), 64'd1);
    #11 reset = 1'b1;

    // streaming
    drive(1, 32'h11, 0, 0); tick();
    chk("str ins0", 64'(oi[0]), 64'h11);
    drive(1, 32'h22, 0, 0); tick();
    chk("str ins1", 64'(oi[0]), 64'h22);
    chk("str ready", 64'(ir[0]), 64'd1);
    drive(1, 32'h33, 0, 0); tick();
    chk("str ins2", 64'(oi[0]), 64'h33);
    chk("str npc2", 64'(on[0]), 64'h1033);

    // stall and skid (u0 unlimited)
    drive(1, 32'hA1, 0, 0); tick();
    drive(1, 32'hB2, 1, 0); tick();
    chk("skid hold A", 64'(oi[0]), 64'hA1);
    chk("skid ready0", 64'(ir[0]), 64'd0);
    drive(1, 32'hC3, 1, 0); tick();
    drive(1, 32'hC3, 1, 0); tick();
    chk("skid still A", 64'(oi[0]), 64'hA1);
    drive(1, 32'hC3, 0, 0); tick();
    chk("skid out B", 64'(oi[0]), 64'hB2);
    chk("skid ready1", 64'(ir[0]), 64'd1);
    drive(1, 32'hC3, 0, 0); tick();
    chk("skid out C", 64'(oi[0]), 64'hC3);

    // hold limit (u1, MAX_HOLD=1)
    drive(1, 32'hD1, 1, 0);
    chk("lim hf c1", 64'(hf[1]), 64'd0);
    tick();
    chk("lim out c1", 64'(oi[1]), 64'hC3);
    drive(1, 32'hD2, 1, 0);
    chk("lim hf c2", 64'(hf[1]), 64'd1);
    chk("unlim hf c2", 64'(hf[0]), 64'd0);
    tick();
    chk("lim out c2", 64'(oi[1]), 64'hD1);
    drive(1, 32'hD2, 1, 0);
    chk("lim hf c3", 64'(hf[1]), 64'd0);
    tick();
    chk("lim out c3", 64'(oi[1]), 64'hD1);
    drive(1, 32'hD3, 1, 0);
    chk("lim hf c4", 64'(hf[1]), 64'd1);
    tick();
    chk("lim out c4", 64'(oi[1]), 64'hD2);

    // flush with u0 holding out=C3, skid=D1
    drive(1, 32'hE5, 0, 1); tick();
    chk("fl valid", 64'(ov[0]), 64'd0);
    chk("fl ready", 64'(ir[0]), 64'd1);
    chk("fl payload", 64'(oi[0]), 64'hC3);
    drive(0, 32'h0, 0, 0); tick();
    chk("fl no skid out", 64'(ov[0]), 64'd0);
    chk("fl no skid ins", 64'(oi[0]), 64'hC3);

    // bubble collapse
    drive(1, 32'h55, 1, 0);
    chk("bub hf", 64'(hf[0]), 64'd0);
    tick();
    chk("bub valid", 64'(ov[0]), 64'd1);
    chk("bub ins", 64'(oi[0]), 64'h55);
    chk("bub ins u1", 64'(oi[1]), 64'h55);
`ifdef STALL_CNT_EN
    chk("bub sc u0", 64'(sc[0]), 64'd7);
    chk("bub sc u1", 64'(sc[1]), 64'd4);
`endif

    // async reset mid-stall
    drive(1, 32'h66, 1, 0); tick();
    chk("ar pre ready", 64'(ir[0]), 64'd0);
    drive(1, 32'h77, 1, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("ar valid", 64'(ov[0]), 64'd0);
    chk("ar ins", 64'(oi[0]), 64'd0);
    chk("ar npc", 64'(on[0]), 64'd0);
    chk("ar ready", 64'(ir[0]), 64'd1);
    chk("ar valid u1", 64'(ov[1]), 64'd0);
    chk("ar ready u1", 64'(ir[1]), 64'd1);
`ifdef STALL_CNT_EN
    chk("ar sc", 64'(sc[0]), 64'd0);
`endif
    tick();
    #2 reset = 1'b1;

    drive(1, 32'h88, 0, 0); tick();
    chk("post rst ins", 64'(oi[0]), 64'h88);
    drive(1, 32'h99, 1, 0); tick();
    drive(0, 32'h0, 0, 0); tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
